// File: rtl/rdma_xlate_pkg.sv
// Shared types for the RDMA address translator: window entry layout and index-width helper.
// Window entries are sized by DEF_ADDR_W, so instances keep ADDR_W equal to it.
package rdma_xlate_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_TAG_W  = 4;

  typedef struct packed {
    logic                  en;
    logic [DEF_ADDR_W-1:0] base;
    logic [DEF_ADDR_W-1:0] mask;
    logic [DEF_ADDR_W-1:0] offset;
  } win_entry_t;

  // A one-window table still needs a 1-bit index field.
  function automatic int win_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rdma_addr_xlate_if.sv
// Request/response streaming channel between the RDMA request generator and the translator.
interface rdma_addr_xlate_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4,
  parameter int IDX_W  = 2
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_win;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_tag, rsp_hit, rsp_win, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_tag, rsp_hit, rsp_win, rsp_err
  );

endinterface

// File: rtl/rdma_xlate_match.sv
// Combinational priority matcher: lowest-index enabled window whose masked base equals the masked address.
module rdma_xlate_match
  import rdma_xlate_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_WIN = 4,
  parameter int IDX_W   = win_idx_w(NUM_WIN)
) (
  input  logic [ADDR_W-1:0] addr,
  input  win_entry_t        tbl [NUM_WIN],
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] offset
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (tbl[i].en &&
          ((addr & tbl[i].mask[ADDR_W-1:0]) == (tbl[i].base[ADDR_W-1:0] & tbl[i].mask[ADDR_W-1:0]))) begin
        hit    = 1'b1;
        idx    = IDX_W'(i);
        offset = tbl[i].offset[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rdma_addr_xlate.sv
// Multi-window local->remote RDMA address translator, 2-stage valid/ready pipeline.
// Optional hit/miss counters are built when RDMA_XLATE_STATS_EN is defined.
module rdma_addr_xlate
  import rdma_xlate_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_WIN   = 4,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int MISS_PASS = 0,
  localparam int IDX_W    = win_idx_w(NUM_WIN)
) (
  input  logic              clk,
  input  logic              rst,
  rdma_addr_xlate_if.slave  bus,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic [ADDR_W-1:0] cfg_offset
`ifdef RDMA_XLATE_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam bit PASS_MISS = (MISS_PASS != 0);

  win_entry_t        tbl [NUM_WIN];

  logic              s2_ready;
  logic              s1_ready;
  logic              accept;

  logic              m_hit;
  logic [IDX_W-1:0]  m_idx;
  logic [ADDR_W-1:0] m_offset;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic              hit_p1;
  logic [IDX_W-1:0]  win_p1;
  logic [ADDR_W-1:0] off_p1;

  assign s2_ready      = !bus.rsp_valid || bus.rsp_ready;
  assign s1_ready      = !vld_p1 || s2_ready;
  assign bus.req_ready = s1_ready;
  assign accept        = bus.req_valid && s1_ready;

  // Out-of-range indices are dropped; a write lands at the edge, so a same-cycle request sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WIN; i++) tbl[i] <= '0;
    end else if (cfg_we && (int'(cfg_idx) < NUM_WIN)) begin
      tbl[cfg_idx] <= '{en: cfg_en, base: cfg_base, mask: cfg_mask, offset: cfg_offset};
    end
  end

  rdma_xlate_match #(
    .ADDR_W  (ADDR_W),
    .NUM_WIN (NUM_WIN),
    .IDX_W   (IDX_W)
  ) u_match (
    .addr   (bus.req_addr),
    .tbl    (tbl),
    .hit    (m_hit),
    .idx    (m_idx),
    .offset (m_offset)
  );

  // ---- stage 1: capture request and match result (offset frozen here) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           vld_p1 <= 1'b0;
    else if (s1_ready) vld_p1 <= bus.req_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= bus.req_addr;
      tag_p1  <= bus.req_tag;
      hit_p1  <= m_hit;
      win_p1  <= m_idx;
      off_p1  <= m_offset;
    end
  end

  // ---- stage 2: add offset / apply miss policy into the response registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_addr  <= '0;
      bus.rsp_tag   <= '0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_win   <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (s2_ready) begin
      bus.rsp_valid <= vld_p1;
      if (vld_p1) begin
        bus.rsp_addr <= hit_p1 ? (addr_p1 + off_p1) : (PASS_MISS ? addr_p1 : '0);
        bus.rsp_tag  <= tag_p1;
        bus.rsp_hit  <= hit_p1;
        bus.rsp_win  <= hit_p1 ? win_p1 : '0;
        bus.rsp_err  <= !hit_p1 && !PASS_MISS;
      end
    end
  end

`ifdef RDMA_XLATE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Clear takes priority over a same-cycle response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (stat_clr) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      if (bus.rsp_hit) stat_hits   <= sat_inc(stat_hits);
      else             stat_misses <= sat_inc(stat_misses);
    end
  end
`endif

endmodule
